// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: PC enable plus IF/ID, ID/EX, EX/MEM enable/flush.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/flush/load-use event counters.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_ADDR_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] q2_rs1_i,
    input  logic [REG_ADDR_W-1:0] q2_rs2_i,
    input  logic                  q2_use_rs1_i,
    input  logic                  q2_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] q3_rd_i,
    input  logic                  q3_memread_i,
    input  logic                  branch_taken_i,
    input  logic                  imem_ready_i,
    input  logic                  dmem_busy_i,
    output logic                  pc_en_o,
    output logic                  q1q2_en_o,
    output logic                  q1q2_flush_o,
    output logic                  q2q3_en_o,
    output logic                  q2q3_flush_o,
    output logic                  q3q4_en_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o,
    output logic [31:0]           loaduse_cnt_o
`endif
);

    // state | meaning
    // RUN   | normal issue; load-use and fetch-wait hazards are resolved here
    // FLUSH | post-branch window; IF/ID is flushed until cnt ready-cycles have elapsed
    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;

    assign load_use = q3_memread_i && (q3_rd_i != '0) &&
                      ((q2_use_rs1_i && (q2_rs1_i == q3_rd_i)) ||
                       (q2_use_rs2_i && (q2_rs2_i == q3_rd_i)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en_o      = 1'b1;
        q1q2_en_o    = 1'b1;
        q1q2_flush_o = 1'b0;
        q2q3_en_o    = 1'b1;
        q2q3_flush_o = 1'b0;
        q3q4_en_o    = 1'b1;
        if (dmem_busy_i) begin
            pc_en_o   = 1'b0;
            q1q2_en_o = 1'b0;
            q2q3_en_o = 1'b0;
            q3q4_en_o = 1'b0;
        end else if (branch_taken_i) begin
            q1q2_flush_o = 1'b1;
            q2q3_flush_o = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d = ST_FLUSH;
                cnt_d   = 3'(FLUSH_CYCLES - 1);
            end else begin
                state_d = ST_RUN;
                cnt_d   = 3'd0;
            end
        end else if (state_q == ST_FLUSH) begin
            q1q2_flush_o = 1'b1;
            pc_en_o      = imem_ready_i;
            if (imem_ready_i) begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = ST_RUN;
                end
            end
        end else if (load_use) begin
            pc_en_o      = 1'b0;
            q1q2_en_o    = 1'b0;
            q2q3_flush_o = 1'b1;
        end else if (!imem_ready_i) begin
            pc_en_o      = 1'b0;
            q1q2_flush_o = 1'b1;
        end
        // Held in reset the pipeline is kept empty regardless of the inputs.
        if (!rst_n) begin
            pc_en_o      = 1'b0;
            q1q2_en_o    = 1'b0;
            q1q2_flush_o = 1'b1;
            q2q3_en_o    = 1'b0;
            q2q3_flush_o = 1'b1;
            q3q4_en_o    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] loaduse_cnt_q, loaduse_cnt_d;
    logic        branch_evt, lu_evt;

    assign branch_evt = !dmem_busy_i && branch_taken_i;
    assign lu_evt     = !dmem_busy_i && !branch_taken_i && (state_q == ST_RUN) && load_use;

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        loaduse_cnt_d = loaduse_cnt_q;
        if (!pc_en_o && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (branch_evt && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + 32'd1;
        if (lu_evt && (loaduse_cnt_q != '1))
            loaduse_cnt_d = loaduse_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            loaduse_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            loaduse_cnt_q <= loaduse_cnt_d;
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;
    assign loaduse_cnt_o = loaduse_cnt_q;
`endif

endmodule
